win_banner_ctrl: RTL and testbench

Sequencer for the 128×64 one-bit "WIN" banner bitmap renderer. On a win event it slides the banner into position, blinks it for a fixed number of frames, and holds it until the player acknowledges or a timeout expires. It then pulses `win_done` to the game-state logic. It drives the banner's top-left position and a visibility gate that qualifies the renderer's inside-rectangle input; it sits between game-state control and the object drawing mux.

---
 rtl/win_pkg.sv | 23 ++
 rtl/win_banner_ctrl_frame_counter.sv | 31 +++
 rtl/win_banner_ctrl.sv | 160 ++++++++++++++++
 tb/tb_win_banner_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
`default_nettype none
//=============================================================================
// Module   : win_pkg
// Summary  : Shared state encoding and screen/banner geometry for the WIN banner.
// Revision : 1.0 - initial release
//=============================================================================
package win_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SLIDE = 3'd1,
      ST_BLINK = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } win_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int BANNER_W = 128;
   localparam int BANNER_H = 64;

endpackage
`default_nettype wire

// File: rtl/win_banner_ctrl_frame_counter.sv
`default_nettype none
//=============================================================================
// Module   : frame_counter
// Summary  : Counts frame pulses up to a terminal value; tc flags the wrap.
// Revision : 1.0 - initial release
//=============================================================================
module frame_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       startOfFrame,
   input  logic [8:0] terminal,
   output logic       tc
);

   logic [8:0] r_count;

   assign tc = startOfFrame && (r_count == terminal);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear || tc) begin
         r_count <= '0;
      end else if (startOfFrame) begin
         r_count <= r_count + 9'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/win_banner_ctrl.sv
`default_nettype none
//=============================================================================
// Module   : win_banner_ctrl
// Summary  : Slide/blink/hold sequencer for the WIN banner overlay.
// Config   : WIN_BANNER_SLIDE_EN - include the slide-in state (else drop in place)
// Revision : 1.0 - initial release
//=============================================================================
module win_banner_ctrl
   import win_pkg::*;
#(
   parameter int TARGET_X      = (SCREEN_W - BANNER_W) / 2,
   parameter int TARGET_Y      = (SCREEN_H - BANNER_H) / 2,
   parameter int SLIDE_STEP    = 4,
   parameter int BLINK_FRAMES  = 15,
   parameter int BLINK_TOGGLES = 6,
   parameter int HOLD_FRAMES   = 300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        win_evt,
   input  logic        ack,
   input  logic        abort,
   output logic        banner_visible,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        busy,
   output logic        win_done
);

   win_state_t  r_state, w_next_state;
   logic [10:0] r_y, w_y_next;
   logic        r_vis, w_vis_next;
   logic [3:0]  r_tog, w_tog_next;
   logic [3:0]  w_tog_inc;
   logic        r_busy, r_done;
   logic        w_fc_run, w_fc_clear, w_fc_tc;
   logic [8:0]  w_fc_term;

`ifdef WIN_BANNER_SLIDE_EN
   logic [11:0] w_y_sum;
   assign w_y_sum = {1'b0, r_y} + 12'(SLIDE_STEP);
`else
   logic w_unused_step;
   assign w_unused_step = |SLIDE_STEP;
`endif

   assign w_tog_inc  = r_tog + 4'd1;
   assign w_fc_run   = startOfFrame && ((r_state == ST_BLINK) || (r_state == ST_HOLD));
   assign w_fc_clear = (w_next_state != r_state);
   assign w_fc_term  = (r_state == ST_HOLD) ? 9'(HOLD_FRAMES - 1) : 9'(BLINK_FRAMES - 1);

   frame_counter u_frame_counter (
      .clk          (clk),
      .reset        (reset),
      .clear        (w_fc_clear),
      .startOfFrame (w_fc_run),
      .terminal     (w_fc_term),
      .tc           (w_fc_tc)
   );

   always_comb begin
      w_next_state = r_state;
      w_y_next     = r_y;
      w_vis_next   = r_vis;
      w_tog_next   = r_tog;

      case (r_state)
         ST_IDLE: begin
            if (win_evt) begin
`ifdef WIN_BANNER_SLIDE_EN
               w_next_state = ST_SLIDE;
               w_y_next     = 11'd0;
`else
               w_next_state = ST_BLINK;
               w_y_next     = 11'(TARGET_Y);
`endif
               w_vis_next   = 1'b1;
            end
         end
`ifdef WIN_BANNER_SLIDE_EN
         ST_SLIDE: begin
            // Clamp rather than overshoot when TARGET_Y is not a step multiple
            if (startOfFrame) begin
               if (w_y_sum >= 12'(TARGET_Y)) begin
                  w_y_next     = 11'(TARGET_Y);
                  w_next_state = ST_BLINK;
               end else begin
                  w_y_next = w_y_sum[10:0];
               end
            end
         end
`endif
         ST_BLINK: begin
            if (w_fc_tc) begin
               w_vis_next = ~r_vis;
               w_tog_next = w_tog_inc;
               if (w_tog_inc == 4'(BLINK_TOGGLES)) begin
                  w_next_state = ST_HOLD;
                  w_vis_next   = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (ack || w_fc_tc) begin
               w_next_state = ST_DONE;
               w_vis_next   = 1'b0;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
            w_y_next     = 11'd0;
            w_vis_next   = 1'b0;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_y_next     = 11'd0;
            w_vis_next   = 1'b0;
         end
      endcase

      if (w_next_state != r_state) begin
         w_tog_next = 4'd0;
      end

      // Abort outranks everything, including a simultaneous win_evt in IDLE
      if (abort) begin
         w_next_state = ST_IDLE;
         w_y_next     = 11'd0;
         w_vis_next   = 1'b0;
         w_tog_next   = 4'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_y     <= 11'd0;
         r_vis   <= 1'b0;
         r_tog   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_y     <= w_y_next;
         r_vis   <= w_vis_next;
         r_tog   <= w_tog_next;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (w_next_state == ST_DONE);
      end
   end

   assign banner_visible = r_vis;
   assign topLeftX       = 11'(TARGET_X);
   assign topLeftY       = r_y;
   assign busy           = r_busy;
   assign win_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_win_banner_ctrl.sv
`default_nettype none
//=============================================================================
// Module   : tb_win_banner_ctrl
// Summary  : Directed self-checking bench for win_banner_ctrl (default parameters).
// Config   : follows WIN_BANNER_SLIDE_EN to pick slide or drop-in expectations
// Revision : 1.0 - initial release
//=============================================================================
module tb_win_banner_ctrl;

   logic        clk;
   logic        reset;
   logic        startOfFrame;
   logic        win_evt;
   logic        ack;
   logic        abort;
   logic        banner_visible;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        busy;
   logic        win_done;

   int n_checks    = 0;
   int n_pass      = 0;
   int done_pulses = 0;

   win_banner_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .win_evt        (win_evt),
      .ack            (ack),
      .abort          (abort),
      .banner_visible (banner_visible),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .busy           (busy),
      .win_done       (win_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (win_done === 1'b1) done_pulses <= done_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   task automatic pulse_win();
      @(negedge clk);
      win_evt = 1'b1;
      @(negedge clk);
      win_evt = 1'b0;
   endtask

   // Leaves the DUT in BLINK with its frame counter freshly cleared
   task automatic start_seq();
      pulse_win();
      check("evt_busy", busy, 1);
      check("evt_vis", banner_visible, 1);
`ifdef WIN_BANNER_SLIDE_EN
      check("slide_y0", topLeftY, 0);
      for (int f = 1; f <= 52; f++) begin
         if (f == 10) begin
            @(negedge clk);
            win_evt = 1'b1;
            ack     = 1'b1;
            @(negedge clk);
            win_evt = 1'b0;
            ack     = 1'b0;
            check("slide_retrig_y", topLeftY, 36);
         end
         frame();
         check("slide_y", topLeftY, (4 * f > 208) ? 208 : 4 * f);
      end
`else
      check("drop_y", topLeftY, 208);
`endif
   endtask

   // Runs BLINK to completion; ends in HOLD
   task automatic blink_phase();
      for (int f = 1; f <= 90; f++) begin
         frame();
         check("blink_vis", banner_visible, ((f / 15) % 2 == 0) ? 1 : 0);
         if (f == 40) begin
            @(negedge clk);
            ack     = 1'b1;
            win_evt = 1'b1;
            @(negedge clk);
            ack     = 1'b0;
            win_evt = 1'b0;
            check("blink_ign_vis", banner_visible, 1);
            check("blink_ign_busy", busy, 1);
         end
      end
      check("hold_vis", banner_visible, 1);
      check("hold_y", topLeftY, 208);
      check("hold_busy", busy, 1);
   endtask

   initial begin
      int base;
      reset        = 1'b1;
      startOfFrame = 1'b0;
      win_evt      = 1'b0;
      ack          = 1'b0;
      abort        = 1'b0;
      tick();
      tick();
      check("rst_vis", banner_visible, 0);
      check("rst_x", topLeftX, 256);
      check("rst_y", topLeftY, 0);
      check("rst_busy", busy, 0);
      check("rst_done", win_done, 0);
      reset = 1'b0;
      tick();

      // Full sequence with HOLD timing out
      start_seq();
      blink_phase();
      base = done_pulses;
      for (int f = 1; f <= 299; f++) frame();
      check("hold299_done", win_done, 0);
      check("hold299_vis", banner_visible, 1);
      frame();
      check("timeout_done", win_done, 1);
      check("timeout_vis", banner_visible, 0);
      check("timeout_busy", busy, 1);
      tick();
      check("after_done", win_done, 0);
      check("after_busy", busy, 0);
      check("after_y", topLeftY, 0);
      check("timeout_pulses", done_pulses - base, 1);

      // ack coinciding with the timeout frame
      start_seq();
      blink_phase();
      base = done_pulses;
      for (int f = 1; f <= 299; f++) frame();
      @(negedge clk);
      startOfFrame = 1'b1;
      ack          = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      ack          = 1'b0;
      check("both_done", win_done, 1);
      tick();
      tick();
      tick();
      check("both_pulses", done_pulses - base, 1);
      check("both_busy", busy, 0);

      // ack early in HOLD
      start_seq();
      blink_phase();
      base = done_pulses;
      for (int f = 1; f <= 5; f++) frame();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_done", win_done, 1);
      check("ack_busy", busy, 1);
      check("ack_vis", banner_visible, 0);
      tick();
      check("ack_done_end", win_done, 0);
      check("ack_idle", busy, 0);
      check("ack_pulses", done_pulses - base, 1);

      // abort mid-BLINK, then abort racing win_evt in IDLE
      start_seq();
      base = done_pulses;
      for (int f = 1; f <= 20; f++) frame();
      check("pre_abort_vis", banner_visible, 0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_vis", banner_visible, 0);
      check("abort_y", topLeftY, 0);
      check("abort_done", win_done, 0);
      @(negedge clk);
      abort   = 1'b1;
      win_evt = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      win_evt = 1'b0;
      check("abortevt_busy", busy, 0);
      check("abortevt_vis", banner_visible, 0);
      tick();
      check("abort_pulses", done_pulses - base, 0);

      // Asynchronous reset mid-sequence
      start_seq();
      for (int f = 1; f <= 3; f++) frame();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_vis", banner_visible, 0);
      check("arst_y", topLeftY, 0);
      check("arst_x", topLeftX, 256);
      check("arst_done", win_done, 0);
      tick();
      reset = 1'b0;
      tick();
      check("arst_hold_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
